debug_loader: RTL
=================

DEBUG_LOADER -- requirements
Module: debug_loader

Interface
REQ-001 SHALL have parameter MEM_WORDS, default 128, meaning number of 32-bit data-memory words addressable by the loader.
REQ-002 SHALL have port clk_i, input, 1, sole clock; all state changes on rising edge.
REQ-003 SHALL have port rst_i, input, 1, reset, asynchronous and active-high.
REQ-004 SHALL have port cmd_valid_i, input, 1, command word valid.
REQ-005 SHALL have port cmd_data_i, input, 32, command word (header or data).
REQ-006 SHALL have port cmd_ready_o, output, 1, loader accepts word this cycle; transfer = valid & ready at rising edge.
REQ-007 SHALL have port reg_we_o, input-side strobe to register file, output, 1, register-file write enable.
REQ-008 SHALL have ports reg_addr_o (output, 5, register index) and reg_data_o (output, 32, register write data).
REQ-009 SHALL have ports mem_we_o (output, 1), mem_addr_o (output, 32, byte address), mem_data_o (output, 32), data-memory write port.
REQ-010 SHALL have ports cpu_hold_o (output, 1, holds pipeline/PC), done_o (output, 1), err_o (output, 1).

Function
REQ-011 Header word format SHALL be: [31:30] target (00 register file, 01 data memory, 11 end-of-load, 10 invalid); [29:24] ignored; [23:16] count N; [15:0] start word index S.
REQ-012 FSM states SHALL be IDLE, DATA, DONE, ERR; all outputs registered.
REQ-013 IDLE: cmd_ready_o=1; accepted header with target 00/01 and legal range -> DATA with counter=N, index=S, target latched.
REQ-014 IDLE: header target 11 -> DONE; target 10, N=0, register header with S+N>32, or memory header with S+N>MEM_WORDS -> ERR.
REQ-015 DATA: cmd_ready_o=1; each accepted word SHALL produce exactly one write strobe in the cycle immediately after acceptance (1-cycle latency), data = accepted word.
REQ-016 Register write: reg_addr_o = current index[4:0]; index 0 SHALL suppress reg_we_o (r0 stays zero) but still consume the word and advance.
REQ-017 Memory write: mem_addr_o = current index * 4 (byte address, upper bits zero).
REQ-018 Index SHALL increment by 1 and counter decrement by 1 per accepted data word; word taking counter 1->0 returns FSM to IDLE in same edge.
REQ-019 Back-to-back: valid held high SHALL sustain one word per cycle with no bubbles, including header directly after last data word.
REQ-020 cmd_valid_i low in DATA SHALL stall without losing state; strobes low on cycles with no accepted word.
REQ-021 cpu_hold_o SHALL be 1 in IDLE, DATA, ERR; 0 only in DONE.
REQ-022 DONE: cmd_ready_o=0, done_o=1, no strobes; sticky until reset.
REQ-023 ERR: cmd_ready_o=0, err_o=1, cpu_hold_o=1, no strobes; sticky until reset.
REQ-024 Write strobes SHALL never be high in DONE or ERR, and reg_we_o and mem_we_o SHALL never be high together.

Reset
REQ-025 rst_i high SHALL immediately force IDLE, cmd_ready_o=0 while asserted, cpu_hold_o=1, reg_we_o=0, mem_we_o=0, done_o=0, err_o=0, reg_addr_o=0, reg_data_o=0, mem_addr_o=0, mem_data_o=0, counter and index 0.
REQ-026 Reset asserted mid-DATA SHALL abort the transfer with no further strobes; a pending strobe is cancelled; after release the next accepted word is treated as a header.
REQ-027 cmd_ready_o SHALL go to 1 on the first rising edge after rst_i deasserts.

Verification
REQ-028 Header 0x0003_0008 then 10,20,30 back-to-back -> reg_we_o 3 consecutive cycles, addr 8,9,10, data 10,20,30; FSM IDLE after.
REQ-029 Header 0x4002_001E then 0xAAAA_5555, 0x1234 with 2-cycle valid gap -> mem_we_o twice, addr 0x78 then 0x7C, no strobe during gap.
REQ-030 Header 0x0002_0000 then 7,9 -> no strobe for r0, reg_we_o once addr 1 data 9.
REQ-031 Header 0x4001_0080 (S=128, MEM_WORDS=128) -> err_o=1, cmd_ready_o=0, cpu_hold_o=1, no strobes; header 0x0000_0004 (N=0) -> same.
REQ-032 Header 0xC000_0000 -> done_o=1, cpu_hold_o=0, cmd_ready_o=0; further valid words ignored.
REQ-033 rst_i pulsed after 1 of 3 data words -> all outputs at reset values immediately, no further strobes; new header accepted after release.

Source files
------------

// File: rtl/debug_loader.sv
// Debug loader: parses header/data command words from a debug port and writes
// them into the register file or data memory while holding the CPU.
module debug_loader #(
  parameter int MEM_WORDS = 128
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        cmd_valid_i,
  input  logic [31:0] cmd_data_i,
  output logic        cmd_ready_o,
  output logic        reg_we_o,
  output logic [4:0]  reg_addr_o,
  output logic [31:0] reg_data_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_data_o,
  output logic        cpu_hold_o,
  output logic        done_o,
  output logic        err_o
);

  // state | meaning
  // IDLE  | waiting for a header word
  // DATA  | streaming N data words to the latched target
  // DONE  | load finished, CPU released (sticky)
  // ERR   | bad header seen, CPU held (sticky)
  typedef enum logic [1:0] {IDLE, DATA, DONE, ERR} state_t;

  localparam logic [16:0] MEM_LIMIT = 17'(MEM_WORDS);

  state_t      state;
  logic [7:0]  count;
  logic [15:0] index;
  logic        tgt_mem;

  logic        accept;
  logic [1:0]  h_tgt;
  logic [7:0]  h_n;
  logic [15:0] h_s;
  logic [16:0] h_end;
  logic        h_range_ok;

  assign accept     = cmd_valid_i & cmd_ready_o;
  assign h_tgt      = cmd_data_i[31:30];
  assign h_n        = cmd_data_i[23:16];
  assign h_s        = cmd_data_i[15:0];
  assign h_end      = {1'b0, h_s} + {9'b0, h_n};
  assign h_range_ok = h_tgt[0] ? (h_end <= MEM_LIMIT) : (h_end <= 17'd32);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state       <= IDLE;
      count       <= '0;
      index       <= '0;
      tgt_mem     <= 1'b0;
      cmd_ready_o <= 1'b0;
      reg_we_o    <= 1'b0;
      reg_addr_o  <= '0;
      reg_data_o  <= '0;
      mem_we_o    <= 1'b0;
      mem_addr_o  <= '0;
      mem_data_o  <= '0;
      cpu_hold_o  <= 1'b1;
      done_o      <= 1'b0;
      err_o       <= 1'b0;
    end else begin
      reg_we_o <= 1'b0;
      mem_we_o <= 1'b0;
      case (state)
        IDLE: begin
          cmd_ready_o <= 1'b1;
          if (accept) begin
            if (h_tgt == 2'b11) begin
              state       <= DONE;
              cmd_ready_o <= 1'b0;
              done_o      <= 1'b1;
              cpu_hold_o  <= 1'b0;
            end else if (h_tgt == 2'b10 || h_n == 8'd0 || !h_range_ok) begin
              state       <= ERR;
              cmd_ready_o <= 1'b0;
              err_o       <= 1'b1;
            end else begin
              state   <= DATA;
              count   <= h_n;
              index   <= h_s;
              tgt_mem <= h_tgt[0];
            end
          end
        end
        DATA: begin
          cmd_ready_o <= 1'b1;
          if (accept) begin
            if (tgt_mem) begin
              mem_we_o   <= 1'b1;
              mem_addr_o <= {14'b0, index, 2'b00};
              mem_data_o <= cmd_data_i;
            end else begin
              // r0 is hardwired zero: consume the word but never write it
              reg_we_o   <= (index != 16'd0);
              reg_addr_o <= index[4:0];
              reg_data_o <= cmd_data_i;
            end
            index <= index + 16'd1;
            count <= count - 8'd1;
            if (count == 8'd1) state <= IDLE;
          end
        end
        DONE, ERR: cmd_ready_o <= 1'b0;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
